vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates VGA raster timing from a single 50 MHz system clock. A registered
//   divide-by-two produces the 25 MHz pixel clock (vga_clk), and a one-Clk
//   pixel_en strobe advances the horizontal/vertical raster counters once per
//   pixel. Sync and blank are registered together with the counters they
//   describe, so there is no skew between DrawX/DrawY and hs/vs/blank.
//
// Ports:
//   Clk          in   system clock; every register is clocked on its rising edge
//   Reset        in   synchronous active-high reset
//   vga_clk      out  pixel clock (Clk/2), registered
//   pixel_en     out  high for the Clk cycle in which vga_clk is 1 and about to fall
//   hs           out  horizontal sync, active-low
//   vs           out  vertical sync, active-low
//   blank        out  1 = visible (draw) area, 0 = blanking interval
//   sync         out  composite sync, tied low
//   DrawX        out  horizontal counter (10-bit)
//   DrawY        out  vertical counter (10-bit)
//   frame_start  out  one-Clk pulse when the counters wrap to (0,0)
//   frame_count  out  frames completed since reset, wraps modulo 2^16
//
// Raster counters advance on the Clk edge that drops vga_clk, so they are
// stable for the whole high phase of vga_clk. Counter arithmetic is 10-bit
// unsigned; H/V totals above 1023 cannot be represented.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        vga_clk,
    output logic        pixel_en,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Totals beyond the 10-bit counter range would silently alias, so refuse
    // to elaborate such a configuration.
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : gIllegalTotals
        $error("vga_timing_gen: H/V totals must not exceed 1023");
    end

    logic        vgaClk_q,     vgaClk_d;
    logic        pixelEn_q,    pixelEn_d;
    logic [9:0]  drawX_q,      drawX_d;
    logic [9:0]  drawY_q,      drawY_d;
    logic        hs_q,         hs_d;
    logic        vs_q,         vs_d;
    logic        blank_q,      blank_d;
    logic        frameStart_q, frameStart_d;
    logic [15:0] frameCount_q, frameCount_d;

    // Next-state logic. pixel_en mirrors the next vga_clk value, so it is high
    // exactly while vga_clk is high; the edge that ends that cycle drops
    // vga_clk and advances the raster. Sync/blank are decoded from the *next*
    // counter values so that, once registered, they line up with DrawX/DrawY.
    always_comb begin
        vgaClk_d     = ~vgaClk_q;
        pixelEn_d    = ~vgaClk_q;
        drawX_d      = drawX_q;
        drawY_d      = drawY_q;
        frameStart_d = 1'b0;
        frameCount_d = frameCount_q;

        if (pixelEn_q) begin
            if (drawX_q == H_LAST) begin
                drawX_d = 10'd0;
                if (drawY_q == V_LAST) begin
                    drawY_d      = 10'd0;
                    frameStart_d = 1'b1;
                    frameCount_d = frameCount_q + 16'd1;
                end else begin
                    drawY_d = drawY_q + 10'd1;
                end
            end else begin
                drawX_d = drawX_q + 10'd1;
            end
        end

        hs_d    = !((drawX_d >= H_SYNC_FIRST) && (drawX_d <= H_SYNC_LAST));
        vs_d    = !((drawY_d >= V_SYNC_FIRST) && (drawY_d <= V_SYNC_LAST));
        blank_d = (drawX_d < H_VIS) && (drawY_d < V_VIS);
    end

    // State registers. Reset values describe pixel (0,0) with the divider in
    // its low phase, which is also why no frame_start is emitted on reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vgaClk_q     <= 1'b0;
            pixelEn_q    <= 1'b0;
            drawX_q      <= 10'd0;
            drawY_q      <= 10'd0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_q      <= 1'b1;
            frameStart_q <= 1'b0;
            frameCount_q <= 16'd0;
        end else begin
            vgaClk_q     <= vgaClk_d;
            pixelEn_q    <= pixelEn_d;
            drawX_q      <= drawX_d;
            drawY_q      <= drawY_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_q      <= blank_d;
            frameStart_q <= frameStart_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign vga_clk     = vgaClk_q;
    assign pixel_en    = pixelEn_q;
    assign DrawX       = drawX_q;
    assign DrawY       = drawY_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign frame_start = frameStart_q;
    assign frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. One instance uses the default 640x480
// timing and is exercised over the first line; a second, shrunken instance
// (15 x 8 raster) makes whole-frame, multi-frame, reset and wrap behaviour
// cheap to simulate. Edges are counted from reset release; with that count k
// the expected pixel index is k/2, vga_clk is k%2.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rstD;
    logic rstS;

    // Default-timing instance
    logic        vgaClkD, pixelEnD, hsD, vsD, blankD, syncD, frameStartD;
    logic [9:0]  drawXD, drawYD;
    logic [15:0] frameCountD;

    // Small-raster instance: H 8+2+3+2 = 15, V 4+1+2+1 = 8
    logic        vgaClkS, pixelEnS, hsS, vsS, blankS, syncS, frameStartS;
    logic [9:0]  drawXS, drawYS;
    logic [15:0] frameCountS;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    vga_timing_gen dutD (
        .Clk(clk), .Reset(rstD), .vga_clk(vgaClkD), .pixel_en(pixelEnD),
        .hs(hsD), .vs(vsD), .blank(blankD), .sync(syncD),
        .DrawX(drawXD), .DrawY(drawYD),
        .frame_start(frameStartD), .frame_count(frameCountD)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dutS (
        .Clk(clk), .Reset(rstS), .vga_clk(vgaClkS), .pixel_en(pixelEnS),
        .hs(hsS), .vs(vsS), .blank(blankS), .sync(syncS),
        .DrawX(drawXS), .DrawY(drawYS),
        .frame_start(frameStartS), .frame_count(frameCountS)
    );

    // 50 MHz system clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance n rising edges and sample 1 time unit later.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic advanceTo(input int target);
        while (edges < target) applyStimulus(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full small-raster observation at the current edge count.
    task automatic checkSmallRaster(input string tag);
        int p, x, y;
        p = edges / 2;
        x = p % 15;
        y = (p / 15) % 8;
        checkOutput({tag, " DrawX"},   32'(drawXS),   x);
        checkOutput({tag, " DrawY"},   32'(drawYS),   y);
        checkOutput({tag, " vga_clk"}, 32'(vgaClkS),  edges % 2);
        checkOutput({tag, " pix_en"},  32'(pixelEnS), edges % 2);
        checkOutput({tag, " hs"},      32'(hsS),      (x >= 10 && x <= 12) ? 0 : 1);
        checkOutput({tag, " vs"},      32'(vsS),      (y >= 5 && y <= 6) ? 0 : 1);
        checkOutput({tag, " blank"},   32'(blankS),   (x < 8 && y < 4) ? 1 : 0);
    endtask

    task automatic checkSmallReset(input string tag);
        checkOutput({tag, " DrawX"},    32'(drawXS),      0);
        checkOutput({tag, " DrawY"},    32'(drawYS),      0);
        checkOutput({tag, " fcount"},   32'(frameCountS), 0);
        checkOutput({tag, " fstart"},   32'(frameStartS), 0);
        checkOutput({tag, " vga_clk"},  32'(vgaClkS),     0);
        checkOutput({tag, " pix_en"},   32'(pixelEnS),    0);
        checkOutput({tag, " hs"},       32'(hsS),         1);
        checkOutput({tag, " vs"},       32'(vsS),         1);
        checkOutput({tag, " blank"},    32'(blankS),      1);
    endtask

    initial begin
        int pixelEnCount;
        int frameStartCount;

        rstD = 1'b1;
        rstS = 1'b1;

        // ---- Default timing: reset state -----------------------------------
        applyStimulus(3);
        checkOutput("rst vga_clk", 32'(vgaClkD),     0);
        checkOutput("rst pix_en",  32'(pixelEnD),    0);
        checkOutput("rst DrawX",   32'(drawXD),      0);
        checkOutput("rst DrawY",   32'(drawYD),      0);
        checkOutput("rst fcount",  32'(frameCountD), 0);
        checkOutput("rst fstart",  32'(frameStartD), 0);
        checkOutput("rst hs",      32'(hsD),         1);
        checkOutput("rst vs",      32'(vsD),         1);
        checkOutput("rst blank",   32'(blankD),      1);
        checkOutput("rst sync",    32'(syncD),       0);

        // ---- Default timing: first pixels and divider ----------------------
        rstD  = 1'b0;
        edges = 0;
        applyStimulus(1);
        checkOutput("e1 vga_clk", 32'(vgaClkD),  1);
        checkOutput("e1 pix_en",  32'(pixelEnD), 1);
        checkOutput("e1 DrawX",   32'(drawXD),   0);
        checkOutput("e1 blank",   32'(blankD),   1);
        applyStimulus(1);
        checkOutput("e2 vga_clk", 32'(vgaClkD),  0);
        checkOutput("e2 pix_en",  32'(pixelEnD), 0);
        checkOutput("e2 DrawX",   32'(drawXD),   1);
        applyStimulus(1);
        checkOutput("e3 vga_clk", 32'(vgaClkD),  1);
        checkOutput("e3 DrawX",   32'(drawXD),   1);

        // ---- Default timing: one line --------------------------------------
        advanceTo(1278);
        checkOutput("x639 DrawX", 32'(drawXD), 639);
        checkOutput("x639 blank", 32'(blankD), 1);
        advanceTo(1280);
        checkOutput("x640 DrawX", 32'(drawXD), 640);
        checkOutput("x640 blank", 32'(blankD), 0);
        advanceTo(1310);
        checkOutput("x655 hs", 32'(hsD), 1);
        advanceTo(1311);
        checkOutput("x655b hs", 32'(hsD), 1);
        advanceTo(1312);
        checkOutput("x656 DrawX", 32'(drawXD), 656);
        checkOutput("x656 hs",    32'(hsD),    0);
        advanceTo(1502);
        checkOutput("x751 hs", 32'(hsD), 0);
        advanceTo(1504);
        checkOutput("x752 DrawX", 32'(drawXD), 752);
        checkOutput("x752 hs",    32'(hsD),    1);
        advanceTo(1598);
        checkOutput("x799 DrawX", 32'(drawXD), 799);
        checkOutput("x799 DrawY", 32'(drawYD), 0);
        checkOutput("x799 blank", 32'(blankD), 0);
        checkOutput("x799 vs",    32'(vsD),    1);
        advanceTo(1600);
        checkOutput("y1 DrawX",  32'(drawXD),      0);
        checkOutput("y1 DrawY",  32'(drawYD),      1);
        checkOutput("y1 blank",  32'(blankD),      1);
        checkOutput("y1 fstart", 32'(frameStartD), 0);
        rstD = 1'b1;

        // ---- Small raster: one full frame, every edge ----------------------
        rstS  = 1'b0;
        edges = 0;
        pixelEnCount    = 0;
        frameStartCount = 0;
        for (int k = 1; k <= 240; k++) begin
            applyStimulus(1);
            checkSmallRaster("frame1");
            if (pixelEnS === 1'b1 && k < 240) pixelEnCount++;
            if (frameStartS === 1'b1) frameStartCount++;
            if (k < 240) checkOutput("frame1 fstart", 32'(frameStartS), 0);
        end
        checkOutput("frame1 pix_en count", 32'(pixelEnCount), 120);
        checkOutput("frame1 wrap fstart",  32'(frameStartS),  1);
        checkOutput("frame1 fcount",       32'(frameCountS),  1);

        // ---- Small raster: frames 2 and 3 ----------------------------------
        for (int k = 241; k <= 720; k++) begin
            applyStimulus(1);
            if (frameStartS === 1'b1) frameStartCount++;
        end
        checkOutput("3frames fstart count", 32'(frameStartCount), 3);
        checkOutput("3frames fcount",       32'(frameCountS),     3);
        checkOutput("3frames DrawX",        32'(drawXS),          0);
        checkOutput("3frames DrawY",        32'(drawYS),          0);
        applyStimulus(1);
        checkOutput("3frames fstart width", 32'(frameStartS), 0);

        // ---- Small raster: reset mid-frame ---------------------------------
        advanceTo(820);
        checkOutput("mid DrawX", 32'(drawXS), 5);
        checkOutput("mid DrawY", 32'(drawYS), 3);
        rstS = 1'b1;
        applyStimulus(1);
        checkSmallReset("midrst");

        // ---- Small raster: reset exactly when a wrap would happen ----------
        rstS  = 1'b0;
        edges = 0;
        advanceTo(239);
        checkOutput("prewrap DrawX",  32'(drawXS),   14);
        checkOutput("prewrap DrawY",  32'(drawYS),   7);
        checkOutput("prewrap pix_en", 32'(pixelEnS), 1);
        rstS = 1'b1;
        applyStimulus(1);
        checkSmallReset("wraprst");

        // ---- Small raster: frame_count 0xFFFF rolls over -------------------
        rstS  = 1'b0;
        edges = 0;
        advanceTo(236);
        force dutS.frameCount_q = 16'hFFFF;
        applyStimulus(1);
        release dutS.frameCount_q;
        checkOutput("roll pre fcount", 32'(frameCountS), 32'hFFFF);
        applyStimulus(1);
        checkOutput("roll e238 fcount", 32'(frameCountS), 32'hFFFF);
        checkSmallRaster("roll e238");
        applyStimulus(1);
        checkOutput("roll e239 fstart", 32'(frameStartS), 0);
        applyStimulus(1);
        checkOutput("roll e240 fcount", 32'(frameCountS), 0);
        checkOutput("roll e240 fstart", 32'(frameStartS), 1);
        checkSmallRaster("roll e240");
        applyStimulus(1);
        checkOutput("roll e241 fstart", 32'(frameStartS), 0);
        checkOutput("roll e241 fcount", 32'(frameCountS), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
